rf_dump_reader: RTL and testbench

- Debug readout engine for the CR16 register file.
- On a start pulse it walks register addresses FIRST_REG..LAST_REG through one register-file read port. The read is combinational.
- Each word is captured and streamed out on a valid/ready interface toward the debug/UART path.
- Used for post-run state inspection of r0-r14 and the PSR (address 15) without stopping the testbench or the board.

---
 rtl/cr16_pkg.sv | 21 ++
 rtl/rf_dump_out_reg.sv | 48 ++++
 rtl/rf_dump_reader.sv | 153 +++++++++++++++
 tb/tb_rf_dump_reader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: dump-engine state encoding, PSR index and PSR flag bit positions.
// Also used by the register-file and debug-decoder code.
package cr16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    DONE,
    CSUM
  } dump_state_t;

  localparam int PSR_IDX = 15;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_N = 7;

endpackage

// File: rtl/rf_dump_out_reg.sv
// Output holding register for debug streamers: loads a word, holds it stable under
// back-pressure and drops valid once the consumer takes it.
module rf_dump_out_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  load_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  last_reg;

  // A load wins over a same-cycle transfer so a follow-on word can replace the one leaving.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      addr_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      addr_reg  <= load_addr;
      last_reg  <= load_last;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_addr  = addr_reg;
  assign out_last  = last_reg;

endmodule

// File: rtl/rf_dump_reader.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG through one read port and streams each word.
// Define RF_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module rf_dump_reader
  import cr16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int REGBITS    = 4,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [REGBITS-1:0]    rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [REGBITS-1:0]    out_addr,
  output logic                  out_last
);

  localparam logic [REGBITS-1:0] FIRST_ADDR = REGBITS'(FIRST_REG);
  localparam logic [REGBITS-1:0] LAST_ADDR  = REGBITS'(LAST_REG);

  dump_state_t           state_reg;
  logic [REGBITS-1:0]    rf_addr_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  fire;
  logic                  at_last;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [REGBITS-1:0]    load_addr;
  logic                  load_last;

`ifdef RF_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_reg;
`endif

  assign fire    = out_valid && out_ready;
  // Termination is by address compare so LAST_REG at the top of the range never wraps.
  assign at_last = (rf_addr_reg == LAST_ADDR);

  always_comb begin
    load      = 1'b0;
    load_data = rf_rd_data;
    load_addr = rf_addr_reg;
`ifdef RF_DUMP_CHECKSUM_EN
    load_last = 1'b0;
`else
    load_last = at_last;
`endif
    if (state_reg == READ) begin
      load = 1'b1;
    end
`ifdef RF_DUMP_CHECKSUM_EN
    else if (state_reg == SEND && fire && at_last) begin
      load      = 1'b1;
      load_data = csum_reg;
      load_addr = '0;
      load_last = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rf_addr_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      csum_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg   <= READ;
            rf_addr_reg <= FIRST_ADDR;
            busy_reg    <= 1'b1;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_reg    <= '0;
`endif
          end
        end
        READ: begin
          state_reg <= SEND;
`ifdef RF_DUMP_CHECKSUM_EN
          csum_reg  <= csum_reg ^ rf_rd_data;
`endif
        end
        SEND: begin
          if (fire) begin
            if (at_last) begin
`ifdef RF_DUMP_CHECKSUM_EN
              state_reg <= CSUM;
`else
              state_reg <= DONE;
              done_reg  <= 1'b1;
`endif
            end else begin
              rf_addr_reg <= rf_addr_reg + REGBITS'(1);
              state_reg   <= READ;
            end
          end
        end
        CSUM: begin
          if (fire) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  rf_dump_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REGBITS)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .load_addr (load_addr),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rf_addr = rf_addr_reg;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: full-range and single-register instances against
// a word-list model built from the register-file contents.
module tb_rf_dump_reader;

`ifdef RF_DUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start, busy, done, out_valid, out_ready, out_last;
  logic [3:0]  rf_addr, out_addr;
  logic [15:0] rf_rd_data, out_data;
  logic        start_s, busy_s, done_s, valid_s, ready_s, last_s;
  logic [3:0]  rf_addr_s, addr_s;
  logic [15:0] rd_data_s, data_s;

  logic [15:0] rf [16];
  int checks = 0;
  int errors = 0;

  logic [15:0] obs_data[$], exp_data[$];
  logic [3:0]  obs_addr[$], exp_addr[$];
  logic        obs_last[$], exp_last[$];
  int done_cycle, done_count, hold_err, busy_err, idle_err;

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_addr];
  assign rd_data_s  = rf[rf_addr_s];

  rf_dump_reader #(.DATA_WIDTH(16), .REGBITS(4), .FIRST_REG(0), .LAST_REG(15)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rf_addr(rf_addr), .rf_rd_data(rf_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  rf_dump_reader #(.DATA_WIDTH(16), .REGBITS(4), .FIRST_REG(15), .LAST_REG(15)) dut_single (
    .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
    .rf_addr(rf_addr_s), .rf_rd_data(rd_data_s), .out_valid(valid_s),
    .out_ready(ready_s), .out_data(data_s), .out_addr(addr_s), .out_last(last_s)
  );

  // Expected stream: one word per address in order, optionally followed by the XOR of all of them.
  task automatic build_expected(input int first, input int last);
    logic [15:0] x;
    x = 16'h0;
    exp_data.delete(); exp_addr.delete(); exp_last.delete();
    for (int a = first; a <= last; a++) begin
      exp_data.push_back(rf[a]);
      exp_addr.push_back(4'(a));
      exp_last.push_back((a == last) && (CSUM == 0));
      x = x ^ rf[a];
    end
    if (CSUM != 0) begin
      exp_data.push_back(x);
      exp_addr.push_back(4'd0);
      exp_last.push_back(1'b1);
    end
  endtask

  task automatic preload_spec();
    for (int i = 0; i < 15; i++) rf[i] = 16'h1000 + 16'(i);
    rf[15] = 16'h00C5;
  endtask

  // Runs one dump on the full-range instance, recording transfers and timing.
  // mode 0: ready high, 1: stall word 3 for 5 cycles, 2: random ready.
  task automatic collect(input int mode, input int restart_addr);
    int stall_left;
    int post;
    bit got_done, held;
    logic [15:0] hd;
    logic [3:0]  ha;
    logic        hl;
    stall_left = 5; post = 0; got_done = 0; held = 0;
    hd = '0; ha = '0; hl = 1'b0;
    obs_data.delete(); obs_addr.delete(); obs_last.delete();
    done_cycle = -1; done_count = 0; hold_err = 0; busy_err = 0; idle_err = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (held && (out_valid !== 1'b1 || out_data !== hd || out_addr !== ha || out_last !== hl))
        hold_err++;
      if (mode == 1) begin
        if (out_valid && out_addr == 4'd3 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end else if (mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      held = out_valid && !out_ready;
      hd = out_data; ha = out_addr; hl = out_last;
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_addr.push_back(out_addr);
        obs_last.push_back(out_last);
        $display("  cycle %0d: word addr=%0d data=%h last=%b", c, out_addr, out_data, out_last);
      end
      if (restart_addr >= 0 && out_valid && out_addr == 4'(restart_addr)) start = 1'b1;
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
        if (busy !== 1'b1) busy_err++;
        got_done = 1;
        if (restart_addr >= 0) start = 1'b1;
      end else if (got_done) begin
        post++;
        if (busy !== 1'b0) idle_err++;
        if (post >= 3) break;
      end else if (c >= 1 && busy !== 1'b1) begin
        busy_err++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/valid/last=%b, expected 0000", {busy, done, out_valid, out_last});
    end
    checks++;
    if (out_data !== 16'h0 || out_addr !== 4'h0 || rf_addr !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: got data=%h addr=%0d rf_addr=%0d, expected all 0", out_data, out_addr, rf_addr);
    end
    checks++;
    if ({busy_s, done_s, valid_s, last_s} !== 4'b0000 || data_s !== 16'h0 || addr_s !== 4'h0 || rf_addr_s !== 4'h0) begin
      errors++;
      $display("FAIL reset_single: got busy=%b done=%b valid=%b data=%h, expected all 0", busy_s, done_s, valid_s, data_s);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_full_dump();
    preload_spec();
    build_expected(0, 15);
    collect(0, -1);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL full_count: got %0d words, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL full_word%0d: got data=%h addr=%0d last=%b, expected data=%h addr=%0d last=%b",
                 i, obs_data[i], obs_addr[i], obs_last[i], exp_data[i], exp_addr[i], exp_last[i]);
      end
    end
    checks++;
    if (done_cycle != 33 + CSUM || done_count != 1) begin
      errors++;
      $display("FAIL full_done: got cycle %0d count %0d, expected cycle %0d count 1", done_cycle, done_count, 33 + CSUM);
    end
    checks++;
    if (busy_err != 0 || idle_err != 0) begin
      errors++;
      $display("FAIL full_busy: got %0d busy and %0d idle violations, expected 0", busy_err, idle_err);
    end
    $display("test_full_dump done");
  endtask

  task automatic test_backpressure();
    preload_spec();
    build_expected(0, 15);
    collect(1, -1);
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable cycles, expected 0", hold_err);
    end
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d words, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL stall_word%0d: got data=%h addr=%0d last=%b, expected data=%h addr=%0d last=%b",
                 i, obs_data[i], obs_addr[i], obs_last[i], exp_data[i], exp_addr[i], exp_last[i]);
      end
    end
    checks++;
    if (done_cycle != 38 + CSUM) begin
      errors++;
      $display("FAIL stall_done: got cycle %0d, expected %0d", done_cycle, 38 + CSUM);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_restart_ignored();
    preload_spec();
    build_expected(0, 15);
    collect(0, 7);
    checks++;
    if (obs_data.size() != exp_data.size() || done_count != 1) begin
      errors++;
      $display("FAIL restart_count: got %0d words %0d dones, expected %0d words 1 done",
               obs_data.size(), done_count, exp_data.size());
    end
    checks++;
    if (busy_err != 0 || idle_err != 0 || done_cycle != 33 + CSUM) begin
      errors++;
      $display("FAIL restart_busy: got busy_err=%0d idle_err=%0d done_cycle=%0d, expected 0 0 %0d",
               busy_err, idle_err, done_cycle, 33 + CSUM);
    end
    $display("test_restart_ignored done");
  endtask

  task automatic test_reset_mid_dump();
    bit hit;
    int bad;
    hit = 0; bad = 0;
    preload_spec();
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && out_addr == 4'd9) begin
        hit = 1;
        out_ready = 1'b0;
        reset = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midreset_reach: got no word 9 within 100 cycles, expected word 9");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== 16'h0 || out_addr !== 4'h0 || rf_addr !== 4'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b valid=%b last=%b data=%h addr=%0d rf_addr=%0d, expected all 0",
               busy, done, out_valid, out_last, out_data, out_addr, rf_addr);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy || out_valid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d active cycles after reset, expected 0", bad);
    end
    build_expected(0, 15);
    collect(0, -1);
    checks++;
    if (obs_data.size() != exp_data.size() || (obs_addr.size() > 0 && obs_addr[0] !== 4'd0)) begin
      errors++;
      $display("FAIL midreset_fresh: got %0d words, expected %0d starting at addr 0", obs_data.size(), exp_data.size());
    end
    $display("test_reset_mid_dump done");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
      build_expected(0, 15);
      collect(2, -1);
      checks++;
      if (obs_data.size() != exp_data.size() || done_count != 1 || hold_err != 0) begin
        errors++;
        $display("FAIL random%0d_count: got %0d words %0d dones %0d hold_err, expected %0d words 1 done 0",
                 r, obs_data.size(), done_count, hold_err, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++)
        if (obs_data[i] !== exp_data[i] || obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random%0d_words: got %0d differing words, expected 0", r, bad);
      end
    end
    $display("test_random done");
  endtask

  task automatic test_single_reg();
    int sdone;
    logic [15:0] sdata[$];
    logic [3:0]  saddr[$];
    logic        slast[$];
    sdone = -1;
    preload_spec();
    build_expected(15, 15);
    @(posedge clk); #1;
    start_s = 1'b1;
    ready_s = 1'b1;
    for (int c = 0; c < 20 && sdone < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start_s = 1'b0;
      end
      if (valid_s && ready_s) begin
        sdata.push_back(data_s); saddr.push_back(addr_s); slast.push_back(last_s);
        $display("  single cycle %0d: word addr=%0d data=%h last=%b", c, addr_s, data_s, last_s);
      end
      if (done_s) sdone = c;
    end
    start_s = 1'b0;
    checks++;
    if (sdone != 3 + CSUM) begin
      errors++;
      $display("FAIL single_done: got cycle %0d, expected %0d", sdone, 3 + CSUM);
    end
    checks++;
    if (sdata.size() != exp_data.size()) begin
      errors++;
      $display("FAIL single_count: got %0d words, expected %0d", sdata.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < sdata.size(); i++) begin
      checks++;
      if (sdata[i] !== exp_data[i] || saddr[i] !== exp_addr[i] || slast[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL single_word%0d: got data=%h addr=%0d last=%b, expected data=%h addr=%0d last=%b",
                 i, sdata[i], saddr[i], slast[i], exp_data[i], exp_addr[i], exp_last[i]);
      end
    end
    $display("test_single_reg done");
  endtask

  task automatic test_checksum_pattern();
    for (int i = 0; i < 15; i++) rf[i] = 16'h0001;
    rf[15] = 16'h0000;
    build_expected(0, 15);
    collect(0, -1);
    checks++;
    if (obs_data.size() != 16 + CSUM) begin
      errors++;
      $display("FAIL csum_count: got %0d words, expected %0d", obs_data.size(), 16 + CSUM);
    end else begin
      checks++;
      if (obs_data[obs_data.size()-1] !== exp_data[exp_data.size()-1] || obs_last[obs_last.size()-1] !== 1'b1) begin
        errors++;
        $display("FAIL csum_final: got data=%h last=%b, expected data=%h last=1",
                 obs_data[obs_data.size()-1], obs_last[obs_last.size()-1], exp_data[exp_data.size()-1]);
      end
      checks++;
      if (obs_last[15] !== (CSUM == 0)) begin
        errors++;
        $display("FAIL csum_word15_last: got %b, expected %b", obs_last[15], (CSUM == 0));
      end
    end
    checks++;
    if (done_cycle != 33 + CSUM) begin
      errors++;
      $display("FAIL csum_done: got cycle %0d, expected %0d", done_cycle, 33 + CSUM);
    end
    $display("test_checksum_pattern done");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; start_s = 1'b0; ready_s = 1'b1;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_dump();
    test_random();
    test_single_reg();
    test_checksum_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
